pulse_shaper: RTL and testbench

- Converts an asynchronous, arbitrary-width detector `channel` input into a clean, fixed-width, single-clock-domain `pulse`.
- One output pulse per accepted rising edge.
- Sits between a photon-detector input pin and the downstream time-correlation and counting logic.
- Non-retriggerable: edges that arrive during the pulse or the following dead time are ignored.

---
 rtl/pulse_shaper.sv | 167 ++++++++++++++++
 tb/tb_pulse_shaper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shaper.sv
// Shapes an asynchronous detector input into fixed-width, non-retriggerable pulses.
// Define PULSE_SHAPER_CNT_EN to add saturating event_count / drop_count outputs.
module pulse_shaper #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_WIDTH = 4,
  parameter int DEAD_TIME   = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             channel,
`ifdef PULSE_SHAPER_CNT_EN
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] drop_count,
`endif
  output logic             pulse
);

  localparam int MAX_PD   = (PULSE_WIDTH > DEAD_TIME) ? PULSE_WIDTH : DEAD_TIME;
  localparam int MAX_V    = (MAX_PD > 2) ? MAX_PD : 2;
  localparam int CNT_BITS = $clog2(MAX_V);
  localparam logic [CNT_BITS-1:0] PW_LOAD = CNT_BITS'(PULSE_WIDTH - 1);
  localparam logic [CNT_BITS-1:0] DT_LOAD = CNT_BITS'((DEAD_TIME > 0) ? (DEAD_TIME - 1) : 0);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pulse_shaper: SYNC_STAGES must be >= 2");
    end
    if (PULSE_WIDTH < 1) begin : g_bad_width
      $error("pulse_shaper: PULSE_WIDTH must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PULSE    = 2'd2,
    DEAD     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  state_t                 state_q, state_d;
  logic                   sync_last_s;
  logic                   rise_s;

  assign sync_last_s = sync_q[SYNC_STAGES-1];
  assign rise_s      = sync_last_s & ~prev_q;

  // vld tracks synchronizer fill after reset so WAIT_LOW only trusts a genuinely sampled low.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], channel};
    vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = sync_last_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (vld_q[SYNC_STAGES-1] && !sync_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      IDLE: begin
        if (rise_s) begin
          cnt_d   = PW_LOAD;
          pulse_d = 1'b1;
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_ZERO) begin
          if (DEAD_TIME > 0) begin
            cnt_d   = DT_LOAD;
            state_d = DEAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          pulse_d = 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      vld_q   <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
      pulse_q <= 1'b0;
      state_q <= WAIT_LOW;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

  assign pulse = pulse_q;

`ifdef PULSE_SHAPER_CNT_EN
  localparam logic [CNT_W-1:0] EV_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EV_ONE = CNT_W'(1);

  logic [CNT_W-1:0] event_q, event_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             accept_s;
  logic             drop_s;

  // Saturating event and drop counters.
  always_comb begin
    accept_s = (state_q == IDLE) && rise_s;
    drop_s   = ((state_q == PULSE) || (state_q == DEAD)) && rise_s;
    if (accept_s && (event_q != EV_MAX)) begin
      event_d = event_q + EV_ONE;
    end else begin
      event_d = event_q;
    end
    if (drop_s && (drop_q != EV_MAX)) begin
      drop_d = drop_q + EV_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= {CNT_W{1'b0}};
      drop_q  <= {CNT_W{1'b0}};
    end else begin
      event_q <= event_d;
      drop_q  <= drop_d;
    end
  end

  assign event_count = event_q;
  assign drop_count  = drop_q;
`endif

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed self-checking bench for pulse_shaper at default parameters (2ns clock).
`timescale 1ns/1ps
module tb_pulse_shaper;
  logic clk = 1'b0;
  logic rst;
  logic channel;
  logic pulse;
`ifdef PULSE_SHAPER_CNT_EN
  logic [15:0] event_count;
  logic [15:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Pulse monitor: counts pulse starts and runs whose width is not 4 cycles.
  int   starts   = 0;
  int   bad_runs = 0;
  int   run_len  = 0;
  logic pulse_prev = 1'b0;

  always #1 clk = ~clk;

  pulse_shaper dut (
    .clk         (clk),
    .rst         (rst),
    .channel     (channel),
`ifdef PULSE_SHAPER_CNT_EN
    .event_count (event_count),
    .drop_count  (drop_count),
`endif
    .pulse       (pulse)
  );

  always @(negedge clk) begin
    if (pulse === 1'b1 && pulse_prev === 1'b0) starts++;
    if (pulse === 1'b0 && pulse_prev === 1'b1) begin
      if (run_len != 4) bad_runs++;
      run_len = 0;
    end
    if (pulse === 1'b1) run_len++;
    pulse_prev = pulse;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int s0;
    rst = 1'b1;
    channel = 1'b1;
    cycles(5);
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL reset_pulse actual=%b required=0", pulse);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (event_count !== 16'd0 || drop_count !== 16'd0) begin
      failures++; $display("FAIL reset_counters actual=%0d/%0d required=0/0", event_count, drop_count);
    end
`endif
    s0 = starts;
    rst = 1'b0;
    cycles(12);
    checks++;
    if (starts - s0 !== 0) begin
      failures++; $display("FAIL release_high_pulses actual=%0d required=0", starts - s0);
    end
  endtask

  task automatic test_wait_low();
    int s0, b0;
    s0 = starts; b0 = bad_runs;
    channel = 1'b0; cycles(5);
    channel = 1'b1; cycles(10);
    channel = 1'b0; cycles(10);
    checks++;
    if (starts - s0 !== 1) begin
      failures++; $display("FAIL wait_low_pulses actual=%0d required=1", starts - s0);
    end
    checks++;
    if (bad_runs - b0 !== 0) begin
      failures++; $display("FAIL wait_low_width bad_runs=%0d required=0", bad_runs - b0);
    end
  endtask

  task automatic test_clean_high();
    int s0, b0;
    logic exp;
`ifdef PULSE_SHAPER_CNT_EN
    int e0, d0;
    e0 = event_count; d0 = drop_count;
`endif
    s0 = starts; b0 = bad_runs;
    channel = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycles(1);
      exp = (k >= 3 && k <= 6) ? 1'b1 : 1'b0;
      checks++;
      if (pulse !== exp) begin
        failures++; $display("FAIL latency_edge%0d actual=%b required=%b", k, pulse, exp);
      end
    end
    cycles(3);
    channel = 1'b0;
    cycles(10);
    checks++;
    if (starts - s0 !== 1 || bad_runs - b0 !== 0) begin
      failures++; $display("FAIL clean_high pulses=%0d bad=%0d required=1/0", starts - s0, bad_runs - b0);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (int'(event_count) - e0 !== 1 || int'(drop_count) - d0 !== 0) begin
      failures++; $display("FAIL clean_high_counts ev=%0d drop=%0d required=1/0", int'(event_count) - e0, int'(drop_count) - d0);
    end
`endif
  endtask

  // Rises every 4 cycles against a 6-cycle pulse+dead window: accept, drop, accept, ...
  task automatic test_toggle();
    int s0, b0;
`ifdef PULSE_SHAPER_CNT_EN
    int e0, d0;
    e0 = event_count; d0 = drop_count;
`endif
    s0 = starts; b0 = bad_runs;
    for (int r = 0; r < 6; r++) begin
      channel = 1'b1; cycles(2);
      channel = 1'b0; cycles(2);
    end
    cycles(12);
    checks++;
    if (starts - s0 !== 3 || bad_runs - b0 !== 0) begin
      failures++; $display("FAIL toggle pulses=%0d bad=%0d required=3/0", starts - s0, bad_runs - b0);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (int'(event_count) - e0 !== 3 || int'(drop_count) - d0 !== 3) begin
      failures++; $display("FAIL toggle_counts ev=%0d drop=%0d required=3/3", int'(event_count) - e0, int'(drop_count) - d0);
    end
`endif
  endtask

  task automatic test_rearm();
    int s0, b0;
`ifdef PULSE_SHAPER_CNT_EN
    int e0, d0;
    e0 = event_count; d0 = drop_count;
`endif
    // Second rise lands on the cycle DEAD returns to IDLE: ignored, and the held level never retriggers.
    s0 = starts; b0 = bad_runs;
    channel = 1'b1; cycles(4);
    channel = 1'b0; cycles(2);
    channel = 1'b1; cycles(8);
    channel = 1'b0; cycles(10);
    checks++;
    if (starts - s0 !== 1) begin
      failures++; $display("FAIL rearm_enter_idle pulses=%0d required=1", starts - s0);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (int'(event_count) - e0 !== 1 || int'(drop_count) - d0 !== 1) begin
      failures++; $display("FAIL rearm_enter_idle_counts ev=%0d drop=%0d required=1/1", int'(event_count) - e0, int'(drop_count) - d0);
    end
    e0 = event_count; d0 = drop_count;
`endif
    // One cycle later the rise falls on the first IDLE cycle and is accepted.
    s0 = starts;
    channel = 1'b1; cycles(4);
    channel = 1'b0; cycles(3);
    channel = 1'b1; cycles(2);
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL rearm_dead_cycle actual=%b required=0", pulse);
    end
    cycles(1);
    checks++;
    if (pulse !== 1'b1) begin
      failures++; $display("FAIL rearm_first_idle actual=%b required=1", pulse);
    end
    cycles(8);
    channel = 1'b0; cycles(10);
    checks++;
    if (starts - s0 !== 2 || bad_runs - b0 !== 0) begin
      failures++; $display("FAIL rearm_first_idle_pulses pulses=%0d bad=%0d required=2/0", starts - s0, bad_runs - b0);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (int'(event_count) - e0 !== 2 || int'(drop_count) - d0 !== 0) begin
      failures++; $display("FAIL rearm_first_idle_counts ev=%0d drop=%0d required=2/0", int'(event_count) - e0, int'(drop_count) - d0);
    end
`endif
  endtask

  task automatic test_glitch();
    int s0, b0;
    s0 = starts; b0 = bad_runs;
    channel = 1'b0;
    @(negedge clk);
    #0.5;
    for (int i = 0; i < 12; i++) begin
      channel = ~channel;
      #1;
    end
    cycles(15);
    checks++;
    if (starts - s0 > 1) begin
      failures++; $display("FAIL glitch_pulses actual=%0d required<=1", starts - s0);
    end
    checks++;
    if (bad_runs - b0 !== 0) begin
      failures++; $display("FAIL glitch_width bad_runs=%0d required=0", bad_runs - b0);
    end
  endtask

  task automatic test_two_highs();
    int s0, b0;
`ifdef PULSE_SHAPER_CNT_EN
    int e0, d0;
    e0 = event_count; d0 = drop_count;
`endif
    s0 = starts; b0 = bad_runs;
    channel = 1'b1; cycles(3);
    channel = 1'b0; cycles(17);
    channel = 1'b1; cycles(3);
    channel = 1'b0; cycles(17);
    checks++;
    if (starts - s0 !== 2 || bad_runs - b0 !== 0) begin
      failures++; $display("FAIL two_highs pulses=%0d bad=%0d required=2/0", starts - s0, bad_runs - b0);
    end
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (int'(event_count) - e0 !== 2 || int'(drop_count) - d0 !== 0) begin
      failures++; $display("FAIL two_highs_counts ev=%0d drop=%0d required=2/0", int'(event_count) - e0, int'(drop_count) - d0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int s0, b0, w;
    channel = 1'b1;
    w = 0;
    while (pulse !== 1'b1 && w < 20) begin
      cycles(1);
      w++;
    end
    checks++;
    if (pulse !== 1'b1) begin
      failures++; $display("FAIL reset_mid_timeout actual=%b required=1", pulse);
    end
    cycles(1);
    rst = 1'b1;
    cycles(1);
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL reset_mid_pulse actual=%b required=0", pulse);
    end
    cycles(1);
`ifdef PULSE_SHAPER_CNT_EN
    checks++;
    if (event_count !== 16'd0 || drop_count !== 16'd0) begin
      failures++; $display("FAIL reset_mid_counters actual=%0d/%0d required=0/0", event_count, drop_count);
    end
`endif
    rst = 1'b0;
    cycles(1);
    s0 = starts; b0 = bad_runs;
    cycles(10);
    checks++;
    if (starts - s0 !== 0) begin
      failures++; $display("FAIL reset_mid_held_high pulses=%0d required=0", starts - s0);
    end
    channel = 1'b0; cycles(4);
    channel = 1'b1; cycles(8);
    channel = 1'b0; cycles(10);
    checks++;
    if (starts - s0 !== 1 || bad_runs - b0 !== 0) begin
      failures++; $display("FAIL reset_mid_rearm pulses=%0d bad=%0d required=1/0", starts - s0, bad_runs - b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    channel = 1'b0;
    test_reset();
    test_wait_low();
    test_clean_high();
    test_toggle();
    test_rearm();
    test_glitch();
    test_two_highs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
